// File: rtl/ppi_bus_if.sv
// ppi_bus_if -- CPU-side bus interface and control-word decoder for an
// 8255-compatible programmable peripheral interface.
//
// The asynchronous CPU strobes are synchronised into clk. A1:A0 is decoded
// to port A / B / C / control. The block holds the port output latches,
// the control word and the port C bit set/reset logic. Every committed
// write is also forwarded to the downstream port demux as a one-cycle pulse.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   cs_n, rd_n, wr_n      asynchronous CPU strobes, active low
//   a                     register address (0=PA, 1=PB, 2=PC, 3=control)
//   d_in / d_out, d_oe    CPU write data / registered read data, drive enable
//   pa_in, pb_in, pc_in   port pin inputs (already synchronous to clk)
//   pa_out, pb_out, pc_out  output latches
//   dir                   {PA, PCu, PB, PCl}, 1 = input
//   mode_a, mode_b        group mode fields from the control word
//   mode_err              sticky flag: a mode other than 0 was programmed
//   wr_pulse, wr_addr, wr_data  one-cycle notification of each committed write
module ppi_bus_if #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs_n,
  input  logic          rd_n,
  input  logic          wr_n,
  input  logic [1:0]    a,
  input  logic [DW-1:0] d_in,
  output logic [DW-1:0] d_out,
  output logic          d_oe,
  input  logic [DW-1:0] pa_in,
  input  logic [DW-1:0] pb_in,
  input  logic [DW-1:0] pc_in,
  output logic [DW-1:0] pa_out,
  output logic [DW-1:0] pb_out,
  output logic [DW-1:0] pc_out,
  output logic [3:0]    dir,
  output logic [1:0]    mode_a,
  output logic          mode_b,
  output logic          mode_err,
  output logic          wr_pulse,
  output logic [1:0]    wr_addr,
  output logic [DW-1:0] wr_data
);

  // Strobe synchronisers: bit 0 = cs_n, bit 1 = rd_n, bit 2 = wr_n.
  logic [2:0] strobe_raw;
  logic [2:0] strobe_sync;

  assign strobe_raw = {wr_n, rd_n, cs_n};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          chain_reg <= '1;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], strobe_raw[gi]};
        end
      end
      assign strobe_sync[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic cs_sync;
  logic rd_sync;
  logic wr_sync;
  assign cs_sync = strobe_sync[0];
  assign rd_sync = strobe_sync[1];
  assign wr_sync = strobe_sync[2];

  logic          wr_prev_reg;
  logic          wr_armed_reg;
  logic          hold_cs_reg;
  logic [1:0]    hold_a_reg;
  logic [DW-1:0] hold_d_reg;
  logic [DW-1:0] ctrl_reg;
  logic [DW-1:0] pa_reg;
  logic [DW-1:0] pb_reg;
  logic [DW-1:0] pc_reg;
  logic          mode_err_reg;
  logic          wr_pulse_reg;
  logic [1:0]    wr_addr_reg;
  logic [DW-1:0] wr_data_reg;

  // Capture is blocked after reset until wr_n has been seen high, so a write
  // that straddles reset needs a fresh low/high cycle before it can commit.
  logic capture;
  logic commit;
  logic rd_active;

  assign capture   = wr_armed_reg & ~cs_n & ~wr_n;
  assign commit    = wr_sync & ~wr_prev_reg & hold_cs_reg;
  assign rd_active = ~rd_sync & ~cs_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_prev_reg  <= 1'b1;
      wr_armed_reg <= 1'b0;
    end else begin
      wr_prev_reg <= wr_sync;
      if (wr_n) begin
        wr_armed_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cs_reg  <= 1'b0;
      hold_a_reg   <= 2'd0;
      hold_d_reg   <= '0;
      ctrl_reg     <= 8'h9B;
      pa_reg       <= '0;
      pb_reg       <= '0;
      pc_reg       <= '0;
      mode_err_reg <= 1'b0;
      wr_pulse_reg <= 1'b0;
      wr_addr_reg  <= 2'd0;
      wr_data_reg  <= '0;
    end else begin
      wr_pulse_reg <= 1'b0;
      if (commit) begin
        hold_cs_reg  <= 1'b0;
        wr_pulse_reg <= 1'b1;
        wr_addr_reg  <= hold_a_reg;
        wr_data_reg  <= hold_d_reg;
        case (hold_a_reg)
          2'd0: pa_reg <= hold_d_reg;
          2'd1: pb_reg <= hold_d_reg;
          2'd2: pc_reg <= hold_d_reg;
          default: begin
            if (hold_d_reg[7]) begin
              // Mode set: new control word, all latches cleared. Only mode 0
              // is implemented; other modes just raise the sticky flag.
              ctrl_reg <= hold_d_reg;
              pa_reg   <= '0;
              pb_reg   <= '0;
              pc_reg   <= '0;
              if ((hold_d_reg[6:5] != 2'b00) || hold_d_reg[2]) begin
                mode_err_reg <= 1'b1;
              end
            end else begin
              pc_reg[hold_d_reg[3:1]] <= hold_d_reg[0];
            end
          end
        endcase
      end
      // A capture in the commit cycle belongs to a new write, so it wins.
      if (capture) begin
        hold_a_reg  <= a;
        hold_d_reg  <= d_in;
        hold_cs_reg <= 1'b1;
      end
    end
  end

  // Read mux: direction bits choose pin input vs. output latch.
  logic [DW-1:0] rd_mux;

  always_comb begin
    rd_mux = ctrl_reg;
    case (a)
      2'd0: rd_mux = ctrl_reg[4] ? pa_in : pa_reg;
      2'd1: rd_mux = ctrl_reg[1] ? pb_in : pb_reg;
      2'd2: begin
        rd_mux[7:4] = ctrl_reg[3] ? pc_in[7:4] : pc_reg[7:4];
        rd_mux[3:0] = ctrl_reg[0] ? pc_in[3:0] : pc_reg[3:0];
      end
      default: rd_mux = ctrl_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_out <= '0;
      d_oe  <= 1'b0;
    end else if (rd_active) begin
      d_out <= rd_mux;
      d_oe  <= 1'b1;
    end else begin
      d_oe  <= 1'b0;
    end
  end

  assign pa_out   = pa_reg;
  assign pb_out   = pb_reg;
  assign pc_out   = pc_reg;
  assign dir      = {ctrl_reg[4], ctrl_reg[3], ctrl_reg[1], ctrl_reg[0]};
  assign mode_a   = ctrl_reg[6:5];
  assign mode_b   = ctrl_reg[2];
  assign mode_err = mode_err_reg;
  assign wr_pulse = wr_pulse_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;

endmodule
